// File: rtl/sdram_device_model.sv
// Cycle-accurate 16-bit SDR SDRAM device model: decodes controller commands, tracks banks
// and mode register, serves read/write bursts from an internal array, flags protocol errors.
module sdram_device_model #(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned COL_BITS = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_ba,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic        sdram_cke,
    input  logic [1:0]  sdram_dqm,
    inout  wire  [15:0] sdram_dq,
    output logic        mode_valid,
    output logic        protocol_error
);

    localparam int unsigned ADDR_W = 2 + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned DW     = 16;

    typedef enum logic [1:0] {BURST_IDLE, BURST_READ, BURST_WRITE} burst_t;

    logic [DW-1:0] mem [DEPTH];

    burst_t                 state, state_nx;
    logic [1:0]             b_bank, b_bank_nx;
    logic [ROW_BITS-1:0]    b_row, b_row_nx;
    logic [COL_BITS-1:0]    b_col, b_col_nx;
    logic [2:0]             b_k, b_k_nx;
    logic                   b_ap, b_ap_nx;
    logic [1:0]             bl_log2, bl_log2_nx;
    logic                   cl3, cl3_nx;
    logic                   mode_valid_nx, protocol_error_nx;
    logic [3:0]             bank_open, bank_open_nx;
    logic [ROW_BITS-1:0]    bank_row [4];
    logic [ROW_BITS-1:0]    bank_row_nx [4];
    logic [1:0]             pipe_v, pipe_v_nx;
    logic [DW-1:0]          pipe_d0, pipe_d0_nx, pipe_d1, pipe_d1_nx;
    logic                   out_v, out_v_nx;
    logic [DW-1:0]          out_d, out_d_nx;
    logic [1:0]             out_en, out_en_nx;
    logic [1:0]             dqm_q, dqm_nx;

    logic                   beat_v, beat_wr, beat_ap;
    logic [1:0]             beat_bank;
    logic [ROW_BITS-1:0]    beat_row;
    logic [COL_BITS-1:0]    beat_base, beat_col, col_mask;
    logic [2:0]             beat_k, k_mask;
    logic [ADDR_W-1:0]      beat_addr;
    logic [DW-1:0]          rd_word;
    logic                   rw_ok, burst_stop;

    logic [3:0] cmd;
    logic cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, cmd_lmr, cmd_bst;
    logic unused;

    assign cmd     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign cmd_act = (cmd == 4'b0011);
    assign cmd_rd  = (cmd == 4'b0101);
    assign cmd_wr  = (cmd == 4'b0100);
    assign cmd_pre = (cmd == 4'b0010);
    assign cmd_ref = (cmd == 4'b0001);
    assign cmd_lmr = (cmd == 4'b0000);
    assign cmd_bst = (cmd == 4'b0110);
    assign unused  = ^sdram_addr;

    // Per-byte tristate drive of the registered read beat
    assign sdram_dq[15:8] = out_en[1] ? out_d[15:8] : 8'bz;
    assign sdram_dq[7:0]  = out_en[0] ? out_d[7:0]  : 8'bz;

    always_comb begin
        state_nx          = state;
        b_bank_nx         = b_bank;
        b_row_nx          = b_row;
        b_col_nx          = b_col;
        b_k_nx            = b_k;
        b_ap_nx           = b_ap;
        bl_log2_nx        = bl_log2;
        cl3_nx            = cl3;
        mode_valid_nx     = mode_valid;
        protocol_error_nx = protocol_error;
        bank_open_nx      = bank_open;
        bank_row_nx       = bank_row;
        pipe_v_nx         = pipe_v;
        pipe_d0_nx        = pipe_d0;
        pipe_d1_nx        = pipe_d1;
        out_v_nx          = out_v;
        out_d_nx          = out_d;
        out_en_nx         = out_en;
        dqm_nx            = dqm_q;
        beat_v            = 1'b0;
        beat_wr           = (state == BURST_WRITE);
        beat_bank         = b_bank;
        beat_row          = b_row;
        beat_base         = b_col;
        beat_k            = b_k;
        beat_ap           = b_ap;

        rw_ok      = (cmd_rd || cmd_wr) && bank_open[sdram_ba] && mode_valid;
        burst_stop = cmd_bst || (cmd_pre && (sdram_addr[10] || (sdram_ba == b_bank)));
        k_mask     = 3'((4'd1 << bl_log2) - 4'd1);
        col_mask   = COL_BITS'(k_mask);

        // A new accepted READ/WRITE preempts the running burst on its own edge
        if (sdram_cke) begin
            if (rw_ok) begin
                beat_v    = 1'b1;
                beat_wr   = cmd_wr;
                beat_bank = sdram_ba;
                beat_row  = bank_row[sdram_ba];
                beat_base = sdram_addr[COL_BITS-1:0];
                beat_k    = 3'd0;
                beat_ap   = sdram_addr[10];
            end else if (state != BURST_IDLE && !burst_stop) begin
                beat_v = 1'b1;
            end
        end

        beat_col  = (beat_base & ~col_mask) | ((beat_base + COL_BITS'(beat_k)) & col_mask);
        beat_addr = {beat_bank, beat_row, beat_col};
        rd_word   = mem[beat_addr];

        if (sdram_cke) begin
            dqm_nx = sdram_dqm;
            if ((cmd_rd || cmd_wr) && !rw_ok) protocol_error_nx = 1'b1;

            out_v_nx   = pipe_v[0];
            out_d_nx   = pipe_d0;
            out_en_nx  = {2{pipe_v[0]}} & ~dqm_q;
            pipe_v_nx  = {1'b0, pipe_v[1]};
            pipe_d0_nx = pipe_d1;

            if (rw_ok && cmd_wr && ((|pipe_v) || out_v)) begin
                protocol_error_nx = 1'b1;
                pipe_v_nx         = 2'b00;
                out_v_nx          = 1'b0;
                out_en_nx         = 2'b00;
            end

            state_nx = BURST_IDLE;
            if (beat_v) begin
                if (!beat_wr) begin
                    if (cl3) begin
                        pipe_v_nx[1] = 1'b1;
                        pipe_d1_nx   = rd_word;
                    end else begin
                        pipe_v_nx[0] = 1'b1;
                        pipe_d0_nx   = rd_word;
                    end
                end
                if (beat_k == k_mask) begin
                    if (beat_ap) bank_open_nx[beat_bank] = 1'b0;
                end else begin
                    state_nx  = beat_wr ? BURST_WRITE : BURST_READ;
                    b_bank_nx = beat_bank;
                    b_row_nx  = beat_row;
                    b_col_nx  = beat_base;
                    b_k_nx    = beat_k + 3'd1;
                    b_ap_nx   = beat_ap;
                end
            end

            if (cmd_act) begin
                if (bank_open[sdram_ba]) protocol_error_nx = 1'b1;
                bank_open_nx[sdram_ba] = 1'b1;
                bank_row_nx[sdram_ba]  = sdram_addr[ROW_BITS-1:0];
            end
            if (cmd_pre) begin
                if (sdram_addr[10]) bank_open_nx = 4'b0000;
                else                bank_open_nx[sdram_ba] = 1'b0;
            end
            if (cmd_ref && (|bank_open)) protocol_error_nx = 1'b1;
            // Mode is always loaded; illegal fields fall back to BL=1 / CL=3
            if (cmd_lmr) begin
                mode_valid_nx = 1'b1;
                if ((|bank_open) || state != BURST_IDLE || sdram_addr[3]) protocol_error_nx = 1'b1;
                if (sdram_addr[2]) begin
                    bl_log2_nx        = 2'd0;
                    protocol_error_nx = 1'b1;
                end else begin
                    bl_log2_nx = sdram_addr[1:0];
                end
                if (sdram_addr[6:4] == 3'd2) begin
                    cl3_nx = 1'b0;
                end else begin
                    cl3_nx = 1'b1;
                    if (sdram_addr[6:4] != 3'd3) protocol_error_nx = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state          <= BURST_IDLE;
            b_bank         <= 2'd0;
            b_row          <= '0;
            b_col          <= '0;
            b_k            <= 3'd0;
            b_ap           <= 1'b0;
            bl_log2        <= 2'd0;
            cl3            <= 1'b1;
            mode_valid     <= 1'b0;
            protocol_error <= 1'b0;
            bank_open      <= 4'b0000;
            for (int i = 0; i < 4; i++) bank_row[i] <= '0;
            pipe_v         <= 2'b00;
            pipe_d0        <= '0;
            pipe_d1        <= '0;
            out_v          <= 1'b0;
            out_d          <= '0;
            out_en         <= 2'b00;
            dqm_q          <= 2'b00;
        end else begin
            state          <= state_nx;
            b_bank         <= b_bank_nx;
            b_row          <= b_row_nx;
            b_col          <= b_col_nx;
            b_k            <= b_k_nx;
            b_ap           <= b_ap_nx;
            bl_log2        <= bl_log2_nx;
            cl3            <= cl3_nx;
            mode_valid     <= mode_valid_nx;
            protocol_error <= protocol_error_nx;
            bank_open      <= bank_open_nx;
            bank_row       <= bank_row_nx;
            pipe_v         <= pipe_v_nx;
            pipe_d0        <= pipe_d0_nx;
            pipe_d1        <= pipe_d1_nx;
            out_v          <= out_v_nx;
            out_d          <= out_d_nx;
            out_en         <= out_en_nx;
            dqm_q          <= dqm_nx;
        end
    end

    // Array is never cleared; a set dqm bit keeps that byte
    always_ff @(posedge clk_clk) begin
        if (!reset_reset && beat_v && beat_wr) begin
            if (!sdram_dqm[1]) mem[beat_addr][15:8] <= sdram_dq[15:8];
            if (!sdram_dqm[0]) mem[beat_addr][7:0]  <= sdram_dq[7:0];
        end
    end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model; undriven dq reads as 16'hFFFF through pull-ups.
module tb_sdram_device_model;

    localparam logic [3:0]  NOP = 4'b0111;
    localparam logic [3:0]  ACT = 4'b0011;
    localparam logic [3:0]  RD  = 4'b0101;
    localparam logic [3:0]  WR  = 4'b0100;
    localparam logic [3:0]  PRE = 4'b0010;
    localparam logic [3:0]  LMR = 4'b0000;
    localparam logic [3:0]  BST = 4'b0110;
    localparam logic [15:0] HIZ = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [3:0]  cmd;
    logic        cke;
    logic [1:0]  dqm;
    logic        drv_en;
    logic [15:0] drv_data;
    wire  [15:0] dq;
    logic        mode_valid;
    logic        protocol_error;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign dq = drv_en ? drv_data : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (dq[i]);
    end

    sdram_device_model #(.ROW_BITS(4), .COL_BITS(8)) dut (
        .clk_clk        (clk),
        .reset_reset    (reset),
        .sdram_addr     (addr),
        .sdram_ba       (ba),
        .sdram_cs_n     (cmd[3]),
        .sdram_ras_n    (cmd[2]),
        .sdram_cas_n    (cmd[1]),
        .sdram_we_n     (cmd[0]),
        .sdram_cke      (cke),
        .sdram_dqm      (dqm),
        .sdram_dq       (dq),
        .mode_valid     (mode_valid),
        .protocol_error (protocol_error)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        cmd  = c;
        ba   = b;
        addr = a;
        tick();
        cmd  = NOP;
    endtask

    task automatic expect_dq(input string tag, input logic [15:0] exp);
        tick();
        check(tag, dq, exp);
    endtask

    task automatic write_burst(input logic [1:0] b, input logic [12:0] a,
                               input logic [15:0] base, input logic [15:0] stp, input int n);
        drv_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            drv_data = base + 16'(i) * stp;
            cmd      = (i == 0) ? WR : NOP;
            ba       = b;
            addr     = a;
            tick();
        end
        cmd    = NOP;
        drv_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cmd = NOP; ba = 2'd0; addr = 13'd0; cke = 1'b1;
        dqm = 2'b00; drv_en = 1'b0; drv_data = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        check("rst_dq", dq, HIZ);
        check("rst_mode", 16'(mode_valid), 16'd0);
        check("rst_err", 16'(protocol_error), 16'd0);

        // Read before any mode load
        issue(ACT, 2'd0, 13'd0);
        check("act_ok", 16'(protocol_error), 16'd0);
        issue(RD, 2'd0, 13'd0);
        check("nolmr_err", 16'(protocol_error), 16'd1);
        repeat (4) expect_dq("nolmr_dq", HIZ);
        check("nolmr_mode", 16'(mode_valid), 16'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("err_clear", 16'(protocol_error), 16'd0);

        // CL=2 BL=4 write then read back
        issue(LMR, 2'd0, 13'h022);
        check("lmr_mode", 16'(mode_valid), 16'd1);
        issue(ACT, 2'd1, 13'd3);
        write_burst(2'd1, 13'h010, 16'hA001, 16'h1001, 4);
        issue(RD, 2'd1, 13'h010);
        check("cl2_n0", dq, HIZ);
        expect_dq("cl2_b0", 16'hA001);
        expect_dq("cl2_b1", 16'hB002);
        expect_dq("cl2_b2", 16'hC003);
        expect_dq("cl2_b3", 16'hD004);
        expect_dq("cl2_end", HIZ);
        check("cl2_err", 16'(protocol_error), 16'd0);

        // Wrap within the aligned block
        issue(RD, 2'd1, 13'h012);
        expect_dq("wrap_b0", 16'hC003);
        expect_dq("wrap_b1", 16'hD004);
        expect_dq("wrap_b2", 16'hA001);
        expect_dq("wrap_b3", 16'hB002);
        expect_dq("wrap_end", HIZ);

        // CL=3
        issue(PRE, 2'd1, 13'd0);
        issue(LMR, 2'd0, 13'h032);
        issue(ACT, 2'd1, 13'd3);
        issue(RD, 2'd1, 13'h012);
        expect_dq("cl3_n1", HIZ);
        expect_dq("cl3_b0", 16'hC003);
        expect_dq("cl3_b1", 16'hD004);
        expect_dq("cl3_b2", 16'hA001);
        expect_dq("cl3_b3", 16'hB002);
        expect_dq("cl3_end", HIZ);
        check("cl3_err", 16'(protocol_error), 16'd0);

        // Byte masks on write and read
        write_burst(2'd1, 13'h020, 16'h0000, 16'h1234, 4);
        drv_en = 1'b1; drv_data = 16'hFFFF; dqm = 2'b10;
        cmd = WR; ba = 2'd1; addr = 13'h020;
        tick();
        cmd = NOP; dqm = 2'b11;
        repeat (3) tick();
        dqm = 2'b00; drv_en = 1'b0;
        issue(RD, 2'd1, 13'h020);
        expect_dq("msk_n1", HIZ);
        dqm = 2'b11;
        expect_dq("msk_b0", 16'h00FF);
        dqm = 2'b00;
        expect_dq("msk_b1", HIZ);
        expect_dq("msk_b2", 16'h2468);
        expect_dq("msk_b3", 16'h369C);
        expect_dq("msk_end", HIZ);
        check("msk_err", 16'(protocol_error), 16'd0);

        // BL=8 with burst terminate and precharge interruption
        issue(PRE, 2'd0, 13'h400);
        issue(LMR, 2'd0, 13'h033);
        issue(ACT, 2'd2, 13'd5);
        write_burst(2'd2, 13'h000, 16'h1100, 16'h0001, 8);
        issue(RD, 2'd2, 13'h000);
        expect_dq("bst_n1", HIZ);
        expect_dq("bst_b0", 16'h1100);
        issue(BST, 2'd0, 13'd0);
        check("bst_b1", dq, 16'h1101);
        expect_dq("bst_b2", 16'h1102);
        expect_dq("bst_end0", HIZ);
        expect_dq("bst_end1", HIZ);
        issue(RD, 2'd2, 13'h000);
        expect_dq("pre_n1", HIZ);
        expect_dq("pre_b0", 16'h1100);
        issue(PRE, 2'd2, 13'd0);
        check("pre_b1", dq, 16'h1101);
        expect_dq("pre_b2", 16'h1102);
        expect_dq("pre_end0", HIZ);
        expect_dq("pre_end1", HIZ);
        check("int_err", 16'(protocol_error), 16'd0);

        // Clock suspend while data is on the bus
        issue(ACT, 2'd2, 13'd5);
        issue(RD, 2'd2, 13'h000);
        expect_dq("cke_n1", HIZ);
        expect_dq("cke_b0", 16'h1100);
        cke = 1'b0;
        expect_dq("cke_hold0", 16'h1100);
        expect_dq("cke_hold1", 16'h1100);
        cke = 1'b1;
        for (int i = 1; i < 8; i++) expect_dq("cke_bn", 16'h1100 + 16'(i));
        expect_dq("cke_end", HIZ);
        check("cke_err", 16'(protocol_error), 16'd0);

        // ACTIVE to an already open bank
        issue(ACT, 2'd2, 13'd5);
        check("act_open_err", 16'(protocol_error), 16'd1);

        // Reset in the middle of a read burst
        issue(RD, 2'd2, 13'h000);
        tick();
        expect_dq("rr_b0", 16'h1100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_dq", dq, HIZ);
        check("rr_mode", 16'(mode_valid), 16'd0);
        check("rr_err", 16'(protocol_error), 16'd0);
        expect_dq("rr_after", HIZ);

        // Reset in the middle of a write burst stops array updates
        issue(LMR, 2'd0, 13'h033);
        issue(ACT, 2'd2, 13'd5);
        drv_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv_data = 16'h2200 + 16'(i);
            cmd      = (i == 0) ? WR : NOP;
            ba       = 2'd2;
            addr     = 13'h000;
            reset    = (i == 2);
            tick();
        end
        reset = 1'b0; cmd = NOP; drv_en = 1'b0;
        check("rw_mode", 16'(mode_valid), 16'd0);
        issue(LMR, 2'd0, 13'h033);
        issue(ACT, 2'd2, 13'd5);
        issue(RD, 2'd2, 13'h000);
        expect_dq("rw_n1", HIZ);
        expect_dq("rw_b0", 16'h2200);
        expect_dq("rw_b1", 16'h2201);
        expect_dq("rw_b2", 16'h1102);
        expect_dq("rw_b3", 16'h1103);
        repeat (4) tick();
        check("rw_err", 16'(protocol_error), 16'd0);

        // Reserved burst-length code
        issue(PRE, 2'd0, 13'h400);
        issue(LMR, 2'd0, 13'h024);
        check("bl_code_err", 16'(protocol_error), 16'd1);
        check("bl_code_mode", 16'(mode_valid), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
